// File: rtl/sample_scheduler.sv
// sample_scheduler: launches delays on the delay counter, then holds a sample
// request until the sensor reader acknowledges it, counting completed samples.
// Optional acknowledge-timeout/ERR handling is enabled by SAMPLE_TIMEOUT_EN.
module sample_scheduler #(
  parameter int unsigned DLY_W       = 3,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DLY_W-1:0] period,
  input  logic             err_clr,
  output logic             delay_start,
  output logic [DLY_W-1:0] delay_len,
  input  logic             delay_done,
  output logic             sample_req,
  input  logic             sample_ack,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DLY,
    ST_REQ
`ifdef SAMPLE_TIMEOUT_EN
    , ST_ERR
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [DLY_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;

`ifdef SAMPLE_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
`endif

  // Next-state, latched length, sample count and next registered outputs
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
`ifdef SAMPLE_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (period != '0) begin
            len_d   = period;
            state_d = ST_START;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_START: state_d = ST_WAIT_DLY;
      ST_WAIT_DLY: begin
        if (delay_done) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (sample_ack) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (enable) begin
            if (period != '0) begin
              len_d   = period;
              state_d = ST_START;
            end else begin
              state_d = ST_REQ;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef SAMPLE_TIMEOUT_EN
        else if (wait_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
`endif
      end
`ifdef SAMPLE_TIMEOUT_EN
      ST_ERR: begin
        if (err_clr) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef SAMPLE_TIMEOUT_EN
    // Ack-wait count only advances while a request stays pending; any entry
    // into REQ (including back-to-back after an ack) restarts it from zero.
    if (state_q == ST_REQ && state_d == ST_REQ && !sample_ack) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end
`endif

    start_d = (state_d == ST_START);
    req_d   = (state_d == ST_REQ);
    busy_d  = (state_d == ST_START) || (state_d == ST_WAIT_DLY) || (state_d == ST_REQ);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SAMPLE_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
`ifdef SAMPLE_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  assign delay_start = start_q;
  assign delay_len   = len_q;
  assign sample_req  = req_q;
  assign sample_cnt  = cnt_q;
  assign busy        = busy_q;

`ifdef SAMPLE_TIMEOUT_EN
  assign timeout_err = err_q;
`else
  // Without timeout support the flag never sets and the clear is meaningless.
  assign timeout_err = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{err_clr, ACK_TIMEOUT};
`endif

endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler: directed self-checking bench for sample_scheduler.
module tb_sample_scheduler;

  localparam int unsigned DLY_W = 3;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned ACK_T = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [DLY_W-1:0] period;
  logic             err_clr;
  logic             delay_start;
  logic [DLY_W-1:0] delay_len;
  logic             delay_done;
  logic             sample_req;
  logic             sample_ack;
  logic [CNT_W-1:0] sample_cnt;
  logic             busy;
  logic             timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  sample_scheduler #(
    .DLY_W      (DLY_W),
    .CNT_W      (CNT_W),
    .ACK_TIMEOUT(ACK_T)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .period     (period),
    .err_clr    (err_clr),
    .delay_start(delay_start),
    .delay_len  (delay_len),
    .delay_done (delay_done),
    .sample_req (sample_req),
    .sample_ack (sample_ack),
    .sample_cnt (sample_cnt),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Compare every output against its expected value
  task automatic chk_all(input string tag, input int es, input int el, input int er,
                         input int ec, input int eb, input int ee);
    check({tag, "/start"}, 32'(delay_start), 32'(es));
    check({tag, "/len"},   32'(delay_len),   32'(el));
    check({tag, "/req"},   32'(sample_req),  32'(er));
    check({tag, "/cnt"},   32'(sample_cnt),  32'(ec));
    check({tag, "/busy"},  32'(busy),        32'(eb));
    check({tag, "/err"},   32'(timeout_err), 32'(ee));
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    period     = '0;
    err_clr    = 1'b0;
    delay_done = 1'b0;
    sample_ack = 1'b0;

    // 1: reset then idle
    do_reset();
    chk_all("rst", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("idle", 0, 0, 0, 0, 0, 0);
    end

    // 2: single sample, period 3
    period = 3'd3;
    enable = 1'b1;
    step();
    chk_all("s_start", 1, 3, 0, 0, 1, 0);
    enable = 1'b0;
    step();
    chk_all("s_wait1", 0, 3, 0, 0, 1, 0);
    step();
    chk_all("s_wait2", 0, 3, 0, 0, 1, 0);
    step();
    chk_all("s_wait3", 0, 3, 0, 0, 1, 0);
    delay_done = 1'b1;
    step();
    delay_done = 1'b0;
    chk_all("s_req1", 0, 3, 1, 0, 1, 0);
    step();
    chk_all("s_req2", 0, 3, 1, 0, 1, 0);
    step();
    chk_all("s_req3", 0, 3, 1, 0, 1, 0);
    sample_ack = 1'b1;
    step();
    sample_ack = 1'b0;
    chk_all("s_done", 0, 3, 0, 1, 0, 0);
    step();
    chk_all("s_idle", 0, 3, 0, 1, 0, 0);

    // 3: continuous run, period 2 then 5, nine samples (count wraps at 8)
    do_reset();
    period = 3'd2;
    enable = 1'b1;
    step();
    for (int k = 1; k <= 9; k++) begin
      int el;
      el = (k <= 3) ? 2 : 5;
      chk_all($sformatf("c%0d_start", k), 1, el, 0, (k - 1) % 8, 1, 0);
      step();
      chk_all($sformatf("c%0d_wait", k), 0, el, 0, (k - 1) % 8, 1, 0);
      if (k == 3) period = 3'd5;
      delay_done = 1'b1;
      step();
      delay_done = 1'b0;
      chk_all($sformatf("c%0d_req", k), 0, el, 1, (k - 1) % 8, 1, 0);
      sample_ack = 1'b1;
      if (k == 9) enable = 1'b0;
      step();
      sample_ack = 1'b0;
    end
    chk_all("c_end", 0, 5, 0, 1, 0, 0);

`ifdef SAMPLE_TIMEOUT_EN
    // 4: acknowledge timeout, clear, then ack exactly on the last allowed edge
    do_reset();
    period = 3'd0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk_all("t_req1", 0, 0, 1, 0, 1, 0);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk_all($sformatf("t_req%0d", i), 0, 0, 1, 0, 1, 0);
    end
    step();
    chk_all("t_err", 0, 0, 0, 0, 0, 1);
    enable = 1'b1;
    step();
    chk_all("t_err_hold", 0, 0, 0, 0, 0, 1);
    enable  = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk_all("t_clr", 0, 0, 0, 0, 0, 0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    step();
    step();
    chk_all("t_req4b", 0, 0, 1, 0, 1, 0);
    sample_ack = 1'b1;
    step();
    sample_ack = 1'b0;
    chk_all("t_ack4", 0, 0, 0, 1, 0, 0);
`else
    // 4: without timeout support a request waits indefinitely
    do_reset();
    period = 3'd0;
    enable = 1'b1;
    step();
    enable  = 1'b0;
    err_clr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk_all($sformatf("n_req%0d", i), 0, 0, 1, 0, 1, 0);
      step();
    end
    err_clr    = 1'b0;
    sample_ack = 1'b1;
    step();
    sample_ack = 1'b0;
    chk_all("n_ack", 0, 0, 0, 1, 0, 0);
`endif

    // 5: mid-operation reset in WAIT_DLY and REQ; late inputs ignored
    do_reset();
    period = 3'd3;
    enable = 1'b1;
    step();
    chk_all("m_start", 1, 3, 0, 0, 1, 0);
    enable = 1'b0;
    step();
    chk_all("m_wait", 0, 3, 0, 0, 1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("m_rst1", 0, 0, 0, 0, 0, 0);
    delay_done = 1'b1;
    step();
    delay_done = 1'b0;
    chk_all("m_late_done", 0, 0, 0, 0, 0, 0);
    period = 3'd0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk_all("m_req", 0, 0, 1, 0, 1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("m_rst2", 0, 0, 0, 0, 0, 0);
    sample_ack = 1'b1;
    step();
    sample_ack = 1'b0;
    chk_all("m_late_ack", 0, 0, 0, 0, 0, 0);

    // 6: period 0, back-to-back requests across acks
    do_reset();
    period = 3'd0;
    enable = 1'b1;
    step();
    chk_all("z_req", 0, 0, 1, 0, 1, 0);
    sample_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_all($sformatf("z_ack%0d", i), 0, 0, 1, i, 1, 0);
    end
    enable = 1'b0;
    step();
    sample_ack = 1'b0;
    chk_all("z_end", 0, 0, 0, 4, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
